// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - two-requester round-robin arbiter owning the shared 2:1 mux select (optional ARB_LOCK_EN adds Lock)
module mux_arbiter #(
    parameter int QUANTUM = 8,
    parameter int CNT_W   = 4
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             ReqA,
    input  logic             ReqB,
`ifdef ARB_LOCK_EN
    input  logic             Lock,
`endif
    output logic             GntA,
    output logic             GntB,
    output logic             SEL,
    output logic             Busy,
    output logic [CNT_W-1:0] HoldCnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUANTUM - 1);

    state_t           state;
    state_t           state_nxt;
    logic             last_a;
    logic             last_a_nxt;
    logic             sel_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             lock_on;
    logic             expired;

`ifdef ARB_LOCK_EN
    assign lock_on = Lock;
`else
    assign lock_on = 1'b0;
`endif

    // Owner's quantum is used up unless it is locked; the counter sits at CNT_MAX once saturated
    assign expired = (HoldCnt == CNT_MAX) && !lock_on;
    assign cnt_inc = (HoldCnt == CNT_MAX) ? HoldCnt : HoldCnt + 1'b1;

    // Next-state decision plus the registered values that follow from it
    always_comb begin
        state_nxt  = state;
        last_a_nxt = last_a;
        sel_nxt    = SEL;
        cnt_nxt    = '0;
        case (state)
            IDLE: begin
                if (ReqA && (!ReqB || !last_a)) begin
                    state_nxt = OWN_A;
                end else if (ReqB) begin
                    state_nxt = OWN_B;
                end
            end
            OWN_A: begin
                if (!ReqA) begin
                    state_nxt = ReqB ? OWN_B : IDLE;
                end else if (ReqB && expired) begin
                    state_nxt = OWN_B;
                end
            end
            OWN_B: begin
                if (!ReqB) begin
                    state_nxt = ReqA ? OWN_A : IDLE;
                end else if (ReqA && expired) begin
                    state_nxt = OWN_A;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A fresh owner starts counting from zero; a continuing owner counts up and saturates
        if (state_nxt == OWN_A) begin
            sel_nxt    = 1'b1;
            last_a_nxt = 1'b1;
            cnt_nxt    = (state == OWN_A) ? cnt_inc : '0;
        end else if (state_nxt == OWN_B) begin
            sel_nxt    = 1'b0;
            last_a_nxt = 1'b0;
            cnt_nxt    = (state == OWN_B) ? cnt_inc : '0;
        end
    end

    // State and every output are flops so no request path reaches the mux combinationally
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            last_a  <= 1'b0;
            GntA    <= 1'b0;
            GntB    <= 1'b0;
            SEL     <= 1'b0;
            Busy    <= 1'b0;
            HoldCnt <= '0;
        end else begin
            state   <= state_nxt;
            last_a  <= last_a_nxt;
            GntA    <= (state_nxt == OWN_A);
            GntB    <= (state_nxt == OWN_B);
            SEL     <= sel_nxt;
            Busy    <= (state_nxt != IDLE);
            HoldCnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - self-checking bench for mux_arbiter (QUANTUM=8 and QUANTUM=1 instances)
module tb_mux_arbiter;

    logic       Clock;
    logic       Reset_n;
    logic       ReqA;
    logic       ReqB;
    logic       lock_s;
    logic       ga0, gb0, sel0, busy0;
    logic [3:0] hold0;
    logic       ga1, gb1, sel1, busy1;
    logic [3:0] hold1;

    int vectors;
    int miscompares;

    // Reference model per instance: owner 0=none 1=A 2=B, tenure = cycles owned so far
    int quant [2];
    int owner [2];
    int tenure[2];
    bit last_a[2];

    typedef struct {
        bit         ra;
        bit         rb;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[13];

    mux_arbiter #(.QUANTUM(8), .CNT_W(4)) u_q8 (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .ReqA    (ReqA),
        .ReqB    (ReqB),
`ifdef ARB_LOCK_EN
        .Lock    (lock_s),
`endif
        .GntA    (ga0),
        .GntB    (gb0),
        .SEL     (sel0),
        .Busy    (busy0),
        .HoldCnt (hold0)
    );

    mux_arbiter #(.QUANTUM(1), .CNT_W(4)) u_q1 (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .ReqA    (ReqA),
        .ReqB    (ReqB),
`ifdef ARB_LOCK_EN
        .Lock    (lock_s),
`endif
        .GntA    (ga1),
        .GntB    (gb1),
        .SEL     (sel1),
        .Busy    (busy1),
        .HoldCnt (hold1)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k]  = 0;
            tenure[k] = 0;
            last_a[k] = 1'b0;
        end
    endtask

    task automatic grant(input int k, input int who);
        owner[k]  = who;
        tenure[k] = (who == 0) ? 0 : 1;
        if (who != 0) last_a[k] = (who == 1);
    endtask

    task automatic model_step(input int k, input bit ra, input bit rb, input bit lk);
        bit mine, other;
        if (owner[k] == 0) begin
            if (ra && rb)  grant(k, last_a[k] ? 2 : 1);
            else if (ra)   grant(k, 1);
            else if (rb)   grant(k, 2);
        end else begin
            mine  = (owner[k] == 1) ? ra : rb;
            other = (owner[k] == 1) ? rb : ra;
            if (!mine)
                grant(k, other ? 3 - owner[k] : 0);
            else if (other && tenure[k] >= quant[k] && !lk)
                grant(k, 3 - owner[k]);
            else
                tenure[k]++;
        end
    endtask

    function automatic logic [7:0] model_out(input int k);
        int h;
        h = 0;
        if (owner[k] != 0) h = (tenure[k] - 1 < quant[k] - 1) ? tenure[k] - 1 : quant[k] - 1;
        return {owner[k] == 1, owner[k] == 2, last_a[k], owner[k] != 0, 4'(h)};
    endfunction

    task automatic step(input bit ra, input bit rb, input bit lk);
        ReqA   = ra;
        ReqB   = rb;
        lock_s = lk;
        @(posedge Clock);
        #1;
        for (int k = 0; k < 2; k++) model_step(k, ra, rb, lk);
        chk("q8_outputs", {ga0, gb0, sel0, busy0, hold0}, model_out(0));
        chk("q1_outputs", {ga1, gb1, sel1, busy1, hold1}, model_out(1));
        chk("exclusive",  {6'd0, ga0 & gb0, ga1 & gb1}, 8'd0);
    endtask

    initial begin
        bit ra, rb, lk;
        int a_run;
        vectors     = 0;
        miscompares = 0;
        quant[0]    = 8;
        quant[1]    = 1;
        model_reset();

        //            ra    rb    {GntA,GntB,SEL,Busy,HoldCnt}
        tbl[0]  = '{1'b1, 1'b0, 8'b1011_0000};
        tbl[1]  = '{1'b1, 1'b0, 8'b1011_0001};
        tbl[2]  = '{1'b1, 1'b1, 8'b1011_0010};
        tbl[3]  = '{1'b1, 1'b1, 8'b1011_0011};
        tbl[4]  = '{1'b0, 1'b1, 8'b0101_0000};
        tbl[5]  = '{1'b0, 1'b1, 8'b0101_0001};
        tbl[6]  = '{1'b0, 1'b0, 8'b0000_0000};
        tbl[7]  = '{1'b1, 1'b1, 8'b1011_0000};
        tbl[8]  = '{1'b0, 1'b0, 8'b0010_0000};
        tbl[9]  = '{1'b1, 1'b1, 8'b0101_0000};
        tbl[10] = '{1'b0, 1'b0, 8'b0000_0000};
        tbl[11] = '{1'b0, 1'b1, 8'b0101_0000};
        tbl[12] = '{1'b0, 1'b0, 8'b0000_0000};

        Reset_n = 1'b0;
        ReqA    = 1'b0;
        ReqB    = 1'b0;
        lock_s  = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk("reset_state", {ga0, gb0, sel0, busy0, hold0}, 8'd0);
        Reset_n = 1'b1;

        // Directed table: early release, handover, idle SEL hold, tie-breaking by last owner
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].ra, tbl[i].rb, 1'b0);
            chk($sformatf("table_%0d", i), {ga0, gb0, sel0, busy0, hold0}, tbl[i].exp);
        end

        // Asynchronous reset in the middle of a B grant
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        @(negedge Clock);
        Reset_n = 1'b0;
        #1;
        chk("async_reset_q8", {ga0, gb0, sel0, busy0, hold0}, 8'd0);
        chk("async_reset_q1", {ga1, gb1, sel1, busy1, hold1}, 8'd0);
        model_reset();
        @(posedge Clock);
        #1;
        ReqB    = 1'b0;
        Reset_n = 1'b1;

        // Tie straight out of reset: A first for 8 cycles, then B 8, alternating
        a_run = 0;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (i < 8 && ga0) a_run++;
            if (i == 8) chk("tie_first_b", {7'd0, gb0}, 8'd1);
            if (i == 16) chk("tie_back_to_a", {7'd0, ga0}, 8'd1);
        end
        chk("tie_a_first_run", 8'(a_run), 8'd8);

        // Single requester holds for 20 cycles, counter saturates at 7
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        chk("single_sat", {ga0, sel0, 2'b00, hold0}, {1'b1, 1'b1, 2'b00, 4'd7});
        step(1'b0, 1'b0, 1'b0);

`ifdef ARB_LOCK_EN
        // Lock holds A past its quantum while B waits; releasing Lock hands over at once
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b1);
        chk("lock_held_a", {7'd0, ga0}, 8'd1);
        step(1'b1, 1'b1, 1'b0);
        chk("lock_release_b", {7'd0, gb0}, 8'd1);
        step(1'b0, 1'b0, 1'b0);
`endif

        // Randomized sticky requests against the model
        ra = 1'b0;
        rb = 1'b0;
        lk = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) ra = ~ra;
            if ($urandom_range(3) == 0) rb = ~rb;
`ifdef ARB_LOCK_EN
            if ($urandom_range(7) == 0) lk = ~lk;
`endif
            step(ra, rb, lk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester round-robin arbiter that shares the 2:1 select mux (SEL=1 passes A, SEL=0 passes B) between requester A and requester B. It owns the mux SEL line, issues one-hot grants, and bounds each ownership period with a 4-bit hold counter so neither side can starve the other. Sits directly in front of the mux in the shared datapath; requesters drive their data on A/B only while granted.

## Interface
- QUANTUM, 8: maximum grant length in cycles when the other side is waiting; legal range 1..15.
- CNT_W, 4: width of the hold counter; must satisfy QUANTUM <= 2**CNT_W - 1.

- Clock  input  1  rising-edge clock; one clock only.
- Reset_n  input  1  asynchronous, active-low reset.
- ReqA  input  1  requester A wants the mux; level, held until done.
- ReqB  input  1  requester B wants the mux; level, held until done.
- Lock  input  1  owner asks to extend past QUANTUM (present only with ARB_LOCK_EN).
- GntA  output  1  A owns the mux; registered.
- GntB  output  1  B owns the mux; registered.
- SEL  output  1  mux select; 1 = A, 0 = B; registered.
- Busy  output  1  a grant is active (GntA | GntB); registered.
- HoldCnt  output  CNT_W  cycles the current owner has held the grant, saturating.

## Operation
- States: IDLE, OWN_A, OWN_B. Internal LastA flag records last owner.
- Reset: state IDLE, GntA=0, GntB=0, SEL=0, Busy=0, HoldCnt=0, LastA=0 (so A wins the first tie).
- IDLE: ReqA only -> OWN_A; ReqB only -> OWN_B; both -> side not last served (LastA=0 -> OWN_A, else OWN_B); neither -> stay.
- Entering OWN_x: Gntx=1, SEL set accordingly, HoldCnt=0, LastA updated.
- OWN_A each cycle: HoldCnt increments, saturating at QUANTUM-1 (never wraps).
  - ReqA=0 and ReqB=1 -> OWN_B directly (handover, no idle cycle).
  - ReqA=0 and ReqB=0 -> IDLE.
  - ReqA=1, ReqB=1, HoldCnt==QUANTUM-1 -> OWN_B (quantum expiry).
  - otherwise stay.
- OWN_B symmetric with A/B swapped.
- GntA and GntB never both 1. In IDLE SEL holds its last value (no glitch to downstream mux); HoldCnt reads 0.
- QUANTUM=1: with both requesting, ownership alternates every cycle.

## Timing
- Request-to-grant latency: 1 cycle (ReqX sampled at edge n, GntX high after edge n).
- Release latency: 1 cycle after ReqX falls, GntX falls.
- Handover: GntA falls, GntB rises and SEL changes on the same edge; requester must treat grant as valid only while high.
- Under contention, each owner holds exactly QUANTUM cycles.
- Reset_n assertion mid-grant clears all outputs immediately (asynchronous); first grant after release is evaluated at the first Clock edge with Reset_n high.
- All outputs are flops; no combinational path from ReqA/ReqB to any output.

## Configuration
- ARB_LOCK_EN defined: Lock port exists; while owner holds its request and Lock=1, quantum expiry is suppressed (HoldCnt stays saturated); owner dropping its request still releases normally. Lock is ignored in IDLE.
- ARB_LOCK_EN undefined: no Lock port; quantum expiry always enforced.

## Test plan
- Reset: Reset_n=0 mid-OWN_B -> GntB=0, SEL=0, Busy=0, HoldCnt=0 immediately, without a clock edge.
- Single requester: ReqA=1 for 20 cycles, ReqB=0 -> GntA=1 from cycle 1 to 20, SEL=1, HoldCnt saturates at 7, no switch.
- Tie from reset: ReqA=ReqB=1 at cycle 0 -> GntA first for 8 cycles, then GntB 8 cycles, alternating; never both high.
- Early release: A owns, ReqA falls at HoldCnt=3 with ReqB=1 -> next edge GntA=0, GntB=1, SEL=0, HoldCnt=0.
- QUANTUM=1 with both requesting -> grant alternates A,B,A,B every cycle.
- ARB_LOCK_EN: A owns, both requesting, Lock=1 for 30 cycles -> GntA held all 30; Lock falls -> GntB on the next edge.
